// File: rtl/mc_control_fsm.sv
// Multicycle RV32I sequencing FSM: mux selects, enables, ALU control, memory req/ready with timeout,
// halt/trap reporting. Defining RV_M_EXT_EN enables the multi-cycle mul/div wait path.
module mc_control_fsm #(
    parameter int ALU_CTRL_W  = 10,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  less,
    input  logic                  mem_ready,
    input  logic                  md_done,
    output logic                  pc_en,
    output logic                  ir_en,
    output logic                  reg_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic                  adr_sel,
    output logic [2:0]            imm_sel,
    output logic [1:0]            srca_sel,
    output logic [1:0]            srcb_sel,
    output logic [1:0]            result_sel,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  md_start,
    output logic                  halted,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [3:0]            state_dbg
);
`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_I_EXEC   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_LOAD_WB  = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BR_CMP   = 4'd8,
        S_BR_DEC   = 4'd9,
        S_LINK     = 4'd10,
        S_JUMP     = 4'd11,
        S_U_EXEC   = 4'd12,
        S_ALU_WB   = 4'd13,
        S_MULDIV   = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_next;
    logic             w_is_md;
    logic             w_illegal;
    logic             w_mem_wait;
    logic             w_timeout;
    logic [9:0]       w_alu;

    assign w_is_md    = (opcode == OP_R) && (funct7 == 7'b0000001);
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                        && !mem_ready;
    // mem_ready in the limit cycle wins over the timeout
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait && (r_cnt == CNT_LIMIT);

    always_comb begin
        w_illegal = 1'b0;
        case (opcode)
            OP_R:                                          w_illegal = w_is_md && !M_EN;
            OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS: w_illegal = 1'b0;
            OP_BR:  w_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_LD:  w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OP_ST:  w_illegal = (funct3 >= 3'b011);
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd2;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd1;
                end else begin
                    case (opcode)
                        OP_R:              w_next = w_is_md ? S_MULDIV : S_R_EXEC;
                        OP_I:              w_next = S_I_EXEC;
                        OP_LD, OP_ST:      w_next = S_MEM_ADDR;
                        OP_BR:             w_next = S_BR_CMP;
                        OP_JAL, OP_JALR:   w_next = S_LINK;
                        OP_LUI, OP_AUIPC:  w_next = S_U_EXEC;
                        OP_SYS: begin
                            w_next       = S_HALT;
                            w_cause_next = 2'd0;
                        end
                        default: begin
                            w_next       = S_HALT;
                            w_cause_next = 2'd1;
                        end
                    endcase
                end
            end
            S_R_EXEC, S_I_EXEC, S_U_EXEC: w_next = S_ALU_WB;
            S_ALU_WB, S_LOAD_WB, S_BR_DEC, S_JUMP: w_next = S_FETCH;
            S_MEM_ADDR: w_next = (opcode == OP_ST) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    w_next = (r_state == S_MEM_RD) ? S_LOAD_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd2;
                end
            end
            S_BR_CMP: w_next = S_BR_DEC;
            S_LINK:   w_next = S_JUMP;
            S_MULDIV: w_next = md_done ? S_ALU_WB : S_MULDIV;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_size   = 2'b00;
        adr_sel    = 1'b0;
        imm_sel    = 3'b000;
        srca_sel   = 2'b01;
        srcb_sel   = 2'b10;
        result_sel = 2'b10;
        w_alu      = 10'd0;
        md_start   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                srca_sel   = 2'b00;
                result_sel = 2'b00;
                ir_en      = mem_ready;
                pc_en      = mem_ready;
            end
            S_DECODE: md_start = M_EN && w_is_md && !w_illegal;
            S_R_EXEC: begin
                srca_sel = 2'b10;
                srcb_sel = 2'b00;
                w_alu    = {funct7, funct3};
            end
            S_I_EXEC: begin
                srca_sel = 2'b10;
                srcb_sel = 2'b01;
                w_alu    = (funct3 == 3'b101) ? {funct7, funct3} : {7'd0, funct3};
            end
            S_ALU_WB: begin
                reg_en     = 1'b1;
                result_sel = (M_EN && w_is_md) ? 2'b11 : 2'b10;
            end
            S_MEM_ADDR: begin
                srca_sel = 2'b10;
                srcb_sel = 2'b01;
                imm_sel  = (opcode == OP_ST) ? 3'b001 : 3'b000;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = (r_state == S_MEM_WR);
                adr_sel  = 1'b1;
                mem_size = funct3[1:0];
            end
            S_LOAD_WB: begin
                reg_en     = 1'b1;
                result_sel = 2'b01;
            end
            S_BR_CMP: begin
                srca_sel = 2'b10;
                srcb_sel = 2'b00;
                w_alu    = (funct3[2:1] == 2'b00) ? 10'h100 :
                           (funct3[2:1] == 2'b10) ? 10'h002 : 10'h003;
            end
            S_BR_DEC: begin
                srcb_sel   = 2'b01;
                imm_sel    = 3'b010;
                result_sel = 2'b00;
                case (funct3)
                    3'b000:         pc_en = zero;
                    3'b001:         pc_en = !zero;
                    3'b100, 3'b110: pc_en = less;
                    3'b101, 3'b111: pc_en = !less;
                    default:        pc_en = 1'b0;
                endcase
            end
            S_LINK: begin
                result_sel = 2'b00;
                reg_en     = 1'b1;
            end
            S_JUMP: begin
                srcb_sel   = 2'b01;
                result_sel = 2'b00;
                pc_en      = 1'b1;
                if (opcode == OP_JALR) begin
                    srca_sel = 2'b10;
                    w_alu    = 10'h200;
                end else begin
                    imm_sel = 3'b011;
                end
            end
            S_U_EXEC: begin
                srca_sel = (opcode == OP_LUI) ? 2'b11 : 2'b01;
                srcb_sel = 2'b01;
                imm_sel  = 3'b101;
            end
            default: ;
        endcase
        alu_ctrl   = ALU_CTRL_W'(w_alu);
        halted     = (r_state == S_HALT);
        trap       = (r_state == S_HALT) && (r_cause != 2'd0);
        trap_cause = r_cause;
        state_dbg  = r_state;
        // reset forces every output low, abandoning any request in flight
        if (reset) begin
            pc_en      = 1'b0;
            ir_en      = 1'b0;
            reg_en     = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_size   = 2'b00;
            adr_sel    = 1'b0;
            imm_sel    = 3'b000;
            srca_sel   = 2'b00;
            srcb_sel   = 2'b00;
            result_sel = 2'b00;
            alu_ctrl   = '0;
            md_start   = 1'b0;
            halted     = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'd0;
            state_dbg  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: expected per-cycle traces are built from the instruction rules and
// replayed against the DUT; honours RV_M_EXT_EN the same way as the design.
module tb_mc_control_fsm;
    localparam int TO = 4;
    localparam int AW = 12;
`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6;
    localparam int C_LUI = 7, C_AUIPC = 8, C_MD = 9, C_EBRK = 10, C_ILL = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          zero, less, mem_ready, md_done;
    logic          pc_en, ir_en, reg_en, mem_req, mem_we, adr_sel, md_start, halted, trap;
    logic [1:0]    mem_size, srca_sel, srcb_sel, result_sel, trap_cause;
    logic [2:0]    imm_sel;
    logic [AW-1:0] alu_ctrl;
    logic [3:0]    state_dbg;

    typedef struct packed {
        logic [3:0]    st;
        logic          pc_en;
        logic          ir_en;
        logic          reg_en;
        logic          mem_req;
        logic          mem_we;
        logic [1:0]    mem_size;
        logic          adr_sel;
        logic [2:0]    imm_sel;
        logic [1:0]    srca;
        logic [1:0]    srcb;
        logic [1:0]    res;
        logic [AW-1:0] alu;
        logic          md_start;
        logic          halted;
        logic          trap;
        logic [1:0]    cause;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  rdy;
        logic  mdd;
    } ent_t;

    ent_t  exp_q[$];
    outs_t got_q[$];
    outs_t act;
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.ALU_CTRL_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .less(less), .mem_ready(mem_ready), .md_done(md_done),
        .pc_en(pc_en), .ir_en(ir_en), .reg_en(reg_en), .mem_req(mem_req), .mem_we(mem_we),
        .mem_size(mem_size), .adr_sel(adr_sel), .imm_sel(imm_sel), .srca_sel(srca_sel),
        .srcb_sel(srcb_sel), .result_sel(result_sel), .alu_ctrl(alu_ctrl), .md_start(md_start),
        .halted(halted), .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    always_comb begin
        act.st       = state_dbg;
        act.pc_en    = pc_en;
        act.ir_en    = ir_en;
        act.reg_en   = reg_en;
        act.mem_req  = mem_req;
        act.mem_we   = mem_we;
        act.mem_size = mem_size;
        act.adr_sel  = adr_sel;
        act.imm_sel  = imm_sel;
        act.srca     = srca_sel;
        act.srcb     = srcb_sel;
        act.res      = result_sel;
        act.alu      = alu_ctrl;
        act.md_start = md_start;
        act.halted   = halted;
        act.trap     = trap;
        act.cause    = trap_cause;
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t base(input logic [3:0] st);
        outs_t o;
        o      = '0;
        o.st   = st;
        o.srca = 2'b01;
        o.srcb = 2'b10;
        o.res  = 2'b10;
        return o;
    endfunction

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            7'h33: return (f7 == 7'd1) ? (M_EN ? C_MD : C_ILL) : C_R;
            7'h13: return C_I;
            7'h03: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? C_ILL : C_LD;
            7'h23: return (f3 >= 3'd3) ? C_ILL : C_ST;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? C_ILL : C_BR;
            7'h6F: return C_JAL;
            7'h67: return C_JALR;
            7'h37: return C_LUI;
            7'h17: return C_AUIPC;
            7'h73: return C_EBRK;
            default: return C_ILL;
        endcase
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic mdd);
        ent_t e;
        e.o   = o;
        e.rdy = rdy;
        e.mdd = mdd;
        exp_q.push_back(e);
    endtask

    task automatic push_halt(input logic [1:0] cause);
        outs_t o;
        for (int i = 0; i < 3; i++) begin
            o        = base(4'd15);
            o.halted = 1'b1;
            o.trap   = (cause != 2'd0);
            o.cause  = cause;
            push(o, rbit(), rbit());
        end
    endtask

    // A memory state tolerates up to TO stall cycles; one more stall halts the core.
    task automatic push_mem(input outs_t tmpl, input int waits, output bit timed_out);
        outs_t o;
        logic  rdy;
        int    n;
        n = (waits > TO) ? TO + 1 : waits + 1;
        for (int i = 0; i < n; i++) begin
            o   = tmpl;
            rdy = (waits <= TO) && (i == waits);
            if (tmpl.st == 4'd0 && rdy) begin
                o.ir_en = 1'b1;
                o.pc_en = 1'b1;
            end
            push(o, rdy, rbit());
        end
        timed_out = (waits > TO);
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic l, input int fw, input int mw, input int mdw,
                         output bit halts);
        outs_t o;
        bit    tmo;
        int    cls;
        cls   = classify(op, f3, f7);
        halts = 1'b0;
        o = base(4'd0); o.mem_req = 1'b1; o.srca = 2'b00; o.res = 2'b00;
        push_mem(o, fw, tmo);
        if (tmo) begin
            push_halt(2'd2);
            halts = 1'b1;
            return;
        end
        o = base(4'd1); o.md_start = (cls == C_MD);
        push(o, rbit(), rbit());
        case (cls)
            C_ILL: begin push_halt(2'd1); halts = 1'b1; end
            C_EBRK: begin push_halt(2'd0); halts = 1'b1; end
            C_R, C_I, C_LUI, C_AUIPC, C_MD: begin
                if (cls == C_R) begin
                    o = base(4'd2); o.srca = 2'b10; o.srcb = 2'b00; o.alu = {2'b00, f7, f3};
                    push(o, rbit(), rbit());
                end else if (cls == C_I) begin
                    o = base(4'd3); o.srca = 2'b10; o.srcb = 2'b01;
                    o.alu = (f3 == 3'd5) ? {2'b00, f7, f3} : {9'd0, f3};
                    push(o, rbit(), rbit());
                end else if (cls == C_MD) begin
                    for (int i = 0; i < mdw; i++) push(base(4'd14), rbit(), 1'b0);
                    push(base(4'd14), rbit(), 1'b1);
                end else begin
                    o = base(4'd12); o.srca = (cls == C_LUI) ? 2'b11 : 2'b01;
                    o.srcb = 2'b01; o.imm_sel = 3'b101;
                    push(o, rbit(), rbit());
                end
                o = base(4'd13); o.reg_en = 1'b1; o.res = (cls == C_MD) ? 2'b11 : 2'b10;
                push(o, rbit(), rbit());
            end
            C_LD, C_ST: begin
                o = base(4'd4); o.srca = 2'b10; o.srcb = 2'b01;
                o.imm_sel = (cls == C_ST) ? 3'b001 : 3'b000;
                push(o, rbit(), rbit());
                o = base((cls == C_ST) ? 4'd7 : 4'd5);
                o.mem_req = 1'b1; o.adr_sel = 1'b1; o.mem_we = (cls == C_ST); o.mem_size = f3[1:0];
                push_mem(o, mw, tmo);
                if (tmo) begin
                    push_halt(2'd2);
                    halts = 1'b1;
                end else if (cls == C_LD) begin
                    o = base(4'd6); o.reg_en = 1'b1; o.res = 2'b01;
                    push(o, rbit(), rbit());
                end
            end
            C_BR: begin
                o = base(4'd8); o.srca = 2'b10; o.srcb = 2'b00;
                o.alu = (f3 < 3'd2) ? 12'h100 : (f3 < 3'd6) ? 12'h002 : 12'h003;
                push(o, rbit(), rbit());
                o = base(4'd9); o.srcb = 2'b01; o.imm_sel = 3'b010; o.res = 2'b00;
                case (f3)
                    3'd0: o.pc_en = z;
                    3'd1: o.pc_en = !z;
                    3'd4, 3'd6: o.pc_en = l;
                    default: o.pc_en = !l;
                endcase
                push(o, rbit(), rbit());
            end
            default: begin
                o = base(4'd10); o.res = 2'b00; o.reg_en = 1'b1;
                push(o, rbit(), rbit());
                o = base(4'd11); o.srcb = 2'b01; o.res = 2'b00; o.pc_en = 1'b1;
                if (cls == C_JALR) begin o.srca = 2'b10; o.alu = 12'h200; end
                else o.imm_sel = 3'b011;
                push(o, rbit(), rbit());
            end
        endcase
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after the last cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic l, input int fw, input int mw,
                             input int mdw, output bit halts);
        opcode = op; funct3 = f3; funct7 = f7; zero = z; less = l;
        exp_q.delete();
        got_q.delete();
        build(op, f3, f7, z, l, fw, mw, mdw, halts);
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = exp_q[i].rdy;
            md_done   = exp_q[i].mdd;
            #1;
            got_q.push_back(act);
            @(negedge clk);
        end
        $display("txn op=%h f3=%0d f7=%h z=%0d l=%0d fw=%0d mw=%0d mdw=%0d cycles=%0d halts=%0d",
                 op, f3, f7, z, l, fw, mw, mdw, got_q.size(), halts);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1; md_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        outs_t e;
        reset = 1'b1; mem_ready = 1'b1; md_done = 1'b1; opcode = 7'h63; funct3 = 3'd1;
        for (int i = 0; i < 2; i++) begin
            #1; n_vec++;
            if (act !== '0) begin n_err++; $display("FAIL reset_outs: got %h, expected 0", act); end
            @(negedge clk);
        end
        reset = 1'b0; mem_ready = 1'b0;
        e = base(4'd0); e.mem_req = 1'b1; e.srca = 2'b00; e.res = 2'b00;
        #1; n_vec++;
        if (act !== e) begin n_err++; $display("FAIL reset_fetch: got %h, expected %h", act, e); end
    endtask

    task automatic test_add();
        bit h; int nreg;
        run_instr(7'h33, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0, h);
        nreg = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++; nreg += int'(got_q[i].reg_en);
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL add c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
        n_vec++;
        if (nreg != 1) begin n_err++; $display("FAIL add_reg_en_count: got %0d, expected 1", nreg); end
    endtask

    task automatic test_lw();
        bit h; int nreq;
        run_instr(7'h03, 3'd2, 7'd0, 1'b0, 1'b0, 3, 2, 0, h);
        nreq = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++; nreq += int'(got_q[i].mem_req);
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL lw c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
        n_vec++;
        if (nreq != 7) begin n_err++; $display("FAIL lw_req_cycles: got %0d, expected 7", nreq); end
    endtask

    task automatic test_bne();
        bit h;
        for (int k = 0; k < 2; k++) begin
            run_instr(7'h63, 3'd1, 7'd0, 1'(k), 1'b0, 0, 0, 0, h);
            for (int i = 0; i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i].o) begin
                    n_err++; $display("FAIL bne z=%0d c%0d: got %h, expected %h", k, i, got_q[i], exp_q[i].o);
                end
            end
            n_vec++;
            if (got_q[3].pc_en !== 1'(1 - k)) begin
                n_err++; $display("FAIL bne_pc_en z=%0d: got %b, expected %b", k, got_q[3].pc_en, 1'(1 - k));
            end
        end
    endtask

    task automatic test_timeout();
        bit h;
        run_instr(7'h33, 3'd0, 7'd0, 1'b0, 1'b0, 9, 0, 0, h);
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL fetch_timeout c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
        do_reset();
        run_instr(7'h23, 3'd2, 7'd0, 1'b0, 1'b0, 4, 6, 0, h);
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL store_timeout c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
        do_reset();
    endtask

    task automatic test_illegal_ebreak();
        bit h;
        logic [6:0] ops [5] = '{7'h7F, 7'h73, 7'h63, 7'h03, 7'h23};
        logic [2:0] f3s [5] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd3};
        for (int k = 0; k < 5; k++) begin
            run_instr(ops[k], f3s[k], 7'd0, 1'b0, 1'b0, 1, 0, 0, h);
            for (int i = 0; i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i].o) begin
                    n_err++; $display("FAIL illegal%0d c%0d: got %h, expected %h", k, i, got_q[i], exp_q[i].o);
                end
            end
            reset = 1'b1;
            #1; n_vec++;
            if (act !== '0) begin n_err++; $display("FAIL halt_reset%0d: got %h, expected 0", k, act); end
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        bit h;
        opcode = 7'h33; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1; n_vec++;
        if (mem_req !== 1'b0 || act !== '0) begin
            n_err++; $display("FAIL mid_reset: got mem_req=%b outs=%h, expected 0", mem_req, act);
        end
        @(negedge clk);
        reset = 1'b0;
        run_instr(7'h33, 3'd0, 7'd0, 1'b0, 1'b0, 4, 0, 0, h);
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL after_mid_reset c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_muldiv();
        bit h; int nst;
        run_instr(7'h33, 3'd0, 7'd1, 1'b0, 1'b0, 0, 0, 6, h);
        nst = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++; nst += int'(got_q[i].md_start);
            if (got_q[i] !== exp_q[i].o) begin
                n_err++; $display("FAIL mul c%0d: got %h, expected %h", i, got_q[i], exp_q[i].o);
            end
        end
        n_vec++;
        if (nst != int'(M_EN)) begin
            n_err++; $display("FAIL md_start_pulses: got %0d, expected %0d", nst, int'(M_EN));
        end
        if (h) do_reset();
    endtask

    task automatic test_back_to_back();
        bit h;
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                 7'h17, 7'h73, 7'h7F, 7'h33};
        logic [6:0] op, f7;
        logic [2:0] f3;
        int fw, mw;
        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 11)];
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            fw = ($urandom_range(0, 11) == 0) ? 6 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 11) == 0) ? 5 : int'($urandom_range(0, 4));
            run_instr(op, f3, f7, rbit(), rbit(), fw, mw, int'($urandom_range(0, 7)), h);
            for (int i = 0; i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i].o) begin
                    n_err++; $display("FAIL rand%0d c%0d: got %h, expected %h", t, i, got_q[i], exp_q[i].o);
                end
            end
            if (h) do_reset();
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        zero = 1'b0; less = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_lw();
        test_bne();
        test_timeout();
        test_illegal_ebreak();
        test_mid_reset();
        test_muldiv();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
